// File: rtl/sort_sequencer_if.sv
// Signal bundle between the sort sequencer and its environment: sensor strobe,
// classifier handshake, motor drives and display/tally outputs.
interface sort_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             P;
  logic             cls_valid;
  logic [2:0]       cls_code;
  logic             sample;
  logic             motorL;
  logic             motorR;
  logic             busy;
  logic [2:0]       disp_code;
  logic             disp_valid;
  logic [CNT_W-1:0] cnt_left;
  logic [CNT_W-1:0] cnt_right;
  logic [CNT_W-1:0] cnt_reject;
  logic             timeout_err;

  modport master (
    input  P, cls_valid, cls_code,
    output sample, motorL, motorR, busy, disp_code, disp_valid,
           cnt_left, cnt_right, cnt_reject, timeout_err
  );

  modport slave (
    output P, cls_valid, cls_code,
    input  sample, motorL, motorR, busy, disp_code, disp_valid,
           cnt_left, cnt_right, cnt_reject, timeout_err
  );
endinterface

// File: rtl/sort_sequencer.sv
// One colour-sort cycle per P rise: settle, sample, wait for the classifier,
// drive the bin motor, cool down. Keeps saturating per-bin tallies.
//
// state    | meaning
// S_IDLE   | waiting for a P rise
// S_SETTLE | sensor settling, SETTLE_CYC cycles
// S_SAMPLE | one-cycle sample request to the classifier
// S_WAIT   | waiting for cls_valid, at most TIMEOUT_CYC cycles
// S_DRIVE  | selected motor held for MOTOR_CYC cycles (none for rejects)
// S_COOL   | motors off for COOL_CYC cycles before the next P rise
module sort_sequencer #(
  parameter int SETTLE_CYC  = 2,
  parameter int MOTOR_CYC   = 4,
  parameter int COOL_CYC    = 2,
  parameter int TIMEOUT_CYC = 8,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  sort_sequencer_if.master bus
);

  localparam int MAX_A  = (SETTLE_CYC > MOTOR_CYC) ? SETTLE_CYC : MOTOR_CYC;
  localparam int MAX_B  = (COOL_CYC > TIMEOUT_CYC) ? COOL_CYC : TIMEOUT_CYC;
  localparam int MAXC   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TMR_W  = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_SAMPLE, S_WAIT, S_DRIVE, S_COOL
  } state_t;

  typedef enum logic [1:0] {BIN_REJ, BIN_LEFT, BIN_RIGHT} bin_t;

  function automatic bin_t bin_of(input logic [2:0] code);
    case (code)
      3'd1, 3'd4, 3'd7: bin_of = BIN_LEFT;
      3'd2, 3'd3, 3'd5: bin_of = BIN_RIGHT;
      default:          bin_of = BIN_REJ;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == '1) ? v : v + CNT_W'(1);
  endfunction

  state_t           state, state_nxt;
  bin_t             bin_q, bin_nxt;
  logic [TMR_W-1:0] tmr, tmr_val;
  logic             tmr_load, tc;
  logic             p_q, rise, accept, tmo;

  logic             motor_l_q, motor_r_q;
  logic [2:0]       disp_code_q;
  logic             disp_valid_q, terr_q;
  logic [CNT_W-1:0] cnt_left_q, cnt_right_q, cnt_reject_q;

  assign rise    = bus.P & ~p_q;
  assign tc      = (tmr == '0);
  assign bin_nxt = accept ? bin_of(bus.cls_code) : bin_q;

  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    accept    = 1'b0;
    tmo       = 1'b0;
    case (state)
      S_IDLE: if (rise) begin
        state_nxt = S_SETTLE;
        tmr_load  = 1'b1;
        tmr_val   = TMR_W'(SETTLE_CYC - 1);
      end
      S_SETTLE: if (tc) state_nxt = S_SAMPLE;
      S_SAMPLE: begin
        state_nxt = S_WAIT;
        tmr_load  = 1'b1;
        tmr_val   = TMR_W'(TIMEOUT_CYC - 1);
      end
      S_WAIT: begin
        // a result on the last timeout cycle still counts
        if (bus.cls_valid) begin
          accept    = 1'b1;
          state_nxt = S_DRIVE;
          tmr_load  = 1'b1;
          tmr_val   = TMR_W'(MOTOR_CYC - 1);
        end else if (tc) begin
          tmo       = 1'b1;
          state_nxt = S_COOL;
          tmr_load  = 1'b1;
          tmr_val   = TMR_W'(COOL_CYC - 1);
        end
      end
      S_DRIVE: if (tc) begin
        state_nxt = S_COOL;
        tmr_load  = 1'b1;
        tmr_val   = TMR_W'(COOL_CYC - 1);
      end
      S_COOL:  if (tc) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      p_q          <= 1'b0;
      bin_q        <= BIN_REJ;
      tmr          <= '0;
      motor_l_q    <= 1'b0;
      motor_r_q    <= 1'b0;
      disp_code_q  <= '0;
      disp_valid_q <= 1'b0;
      terr_q       <= 1'b0;
      cnt_left_q   <= '0;
      cnt_right_q  <= '0;
      cnt_reject_q <= '0;
    end else begin
      state <= state_nxt;
      p_q   <= bus.P;
      bin_q <= bin_nxt;
      if (tmr_load)  tmr <= tmr_val;
      else if (!tc)  tmr <= tmr - TMR_W'(1);
      // motors are registered from the next state so they align with DRIVE
      motor_l_q <= (state_nxt == S_DRIVE) && (bin_nxt == BIN_LEFT);
      motor_r_q <= (state_nxt == S_DRIVE) && (bin_nxt == BIN_RIGHT);
      if (accept) begin
        disp_code_q  <= bus.cls_code;
        disp_valid_q <= 1'b1;
        case (bin_nxt)
          BIN_LEFT:  cnt_left_q   <= sat_inc(cnt_left_q);
          BIN_RIGHT: cnt_right_q  <= sat_inc(cnt_right_q);
          default:   cnt_reject_q <= sat_inc(cnt_reject_q);
        endcase
      end
      if (tmo) begin
        terr_q       <= 1'b1;
        cnt_reject_q <= sat_inc(cnt_reject_q);
      end
    end
  end

  assign bus.sample      = (state == S_SAMPLE);
  assign bus.busy        = (state != S_IDLE);
  assign bus.motorL      = motor_l_q;
  assign bus.motorR      = motor_r_q;
  assign bus.disp_code   = disp_code_q;
  assign bus.disp_valid  = disp_valid_q;
  assign bus.cnt_left    = cnt_left_q;
  assign bus.cnt_right   = cnt_right_q;
  assign bus.cnt_reject  = cnt_reject_q;
  assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_sort_sequencer.sv
// Bench for sort_sequencer: a default instance and a CNT_W=2 instance share
// the same stimulus; outputs are compared with a transaction-level model.
module tb_sort_sequencer;

  localparam int SETTLE  = 2;
  localparam int MOTOR   = 4;
  localparam int COOL    = 2;
  localparam int TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       p;
  logic       cls_valid;
  logic [2:0] cls_code;

  always #5 clk = ~clk;

  sort_sequencer_if #(.CNT_W(8)) bus  ();
  sort_sequencer_if #(.CNT_W(2)) bus2 ();

  assign bus.P          = p;
  assign bus.cls_valid  = cls_valid;
  assign bus.cls_code   = cls_code;
  assign bus2.P         = p;
  assign bus2.cls_valid = cls_valid;
  assign bus2.cls_code  = cls_code;

  sort_sequencer #(.CNT_W(8)) dut  (.clk(clk), .rst(rst), .bus(bus));
  sort_sequencer #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int checks = 0;
  int errors = 0;

  // model of the architecturally visible results
  int m_left, m_right, m_rej, m_disp, m_dvalid, m_terr;

  typedef struct {
    int code;
    int d;        // WAIT cycle carrying cls_valid, 0 = never
    int jitter;   // 0 none, 1 alternating P, 2 random P while busy
    int exp_l;
    int exp_r;
    int exp_busy;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_bin(input int code);
    if (code inside {1, 4, 7}) return 1;
    if (code inside {2, 3, 5}) return 2;
    return 0;
  endfunction

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic model_clear();
    m_left = 0; m_right = 0; m_rej = 0; m_disp = 0; m_dvalid = 0; m_terr = 0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "/cnt_left"},    int'(bus.cnt_left),    m_left);
    chk({tag, "/cnt_right"},   int'(bus.cnt_right),   m_right);
    chk({tag, "/cnt_reject"},  int'(bus.cnt_reject),  m_rej);
    chk({tag, "/disp_code"},   int'(bus.disp_code),   m_disp);
    chk({tag, "/disp_valid"},  int'(bus.disp_valid),  m_dvalid);
    chk({tag, "/timeout_err"}, int'(bus.timeout_err), m_terr);
    chk({tag, "/sat_left"},    int'(bus2.cnt_left),   sat3(m_left));
    chk({tag, "/sat_right"},   int'(bus2.cnt_right),  sat3(m_right));
    chk({tag, "/sat_reject"},  int'(bus2.cnt_reject), sat3(m_rej));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; p = 1'b0; cls_valid = 1'b0; cls_code = 3'd0;
    repeat (2) @(negedge clk);
    chk("reset/busy",   int'(bus.busy),   0);
    chk("reset/sample", int'(bus.sample), 0);
    chk("reset/motors", int'({bus.motorL, bus.motorR}), 0);
    model_clear();
    check_state("reset");
    rst = 1'b0;
  endtask

  // Called at a negedge with P low in the previous cycle; returns at the
  // negedge of the first idle cycle after the sort, P low.
  task automatic run_sort(input int code, input int d, input bit spur,
                          input int jitter, input int exp_busy,
                          output int nb, output int nl, output int nr,
                          output int ns, output int s_idx, output int m_idx,
                          output int both, output bit done);
    int idx;
    int alt;
    idx = 0; nl = 0; nr = 0; ns = 0; s_idx = 0; m_idx = 0; both = 0; done = 0;
    alt = (code + 1) % 8;
    p = 1'b1;
    cls_valid = spur;
    cls_code  = spur ? 3'(alt) : 3'(code);
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (!bus.busy) begin
        if (idx > 0) begin
          done = 1;
          break;
        end
      end else begin
        idx++;
        if (bus.sample) begin
          ns++;
          if (s_idx == 0) s_idx = idx;
        end
        if (bus.motorL) nl++;
        if (bus.motorR) nr++;
        if ((bus.motorL || bus.motorR) && m_idx == 0) m_idx = idx;
        if (bus.motorL && bus.motorR) both++;
      end
      if (idx == 0)                                     p = 1'b1;
      else if (jitter != 0 && idx <= exp_busy - 3)
        p = (jitter == 1) ? (idx % 2 == 0) : 1'($urandom_range(0, 1));
      else                                              p = 1'b0;
      if (d >= 1 && idx == SETTLE + 1 + d) begin
        cls_valid = 1'b1; cls_code = 3'(code);
      end else if (spur && idx <= SETTLE + 1) begin
        cls_valid = 1'b1; cls_code = 3'(alt);
      end else begin
        cls_valid = 1'b0;
      end
    end
    nb = idx;
    p = 1'b0;
    cls_valid = 1'b0;
  endtask

  task automatic apply_sort(input string tag, input int code, input int d,
                            input bit spur, input int jitter, input int exp_l,
                            input int exp_r, input int exp_busy);
    int nb, nl, nr, ns, s_idx, m_idx, both;
    bit done;
    bit acc;
    int b;
    run_sort(code, d, spur, jitter, exp_busy, nb, nl, nr, ns, s_idx, m_idx, both, done);
    chk({tag, "/completed"},   int'(done), 1);
    chk({tag, "/busy_cycles"}, nb, exp_busy);
    chk({tag, "/motorL_cyc"},  nl, exp_l);
    chk({tag, "/motorR_cyc"},  nr, exp_r);
    chk({tag, "/sample_cnt"},  ns, 1);
    chk({tag, "/sample_pos"},  s_idx, SETTLE + 1);
    chk({tag, "/both_motors"}, both, 0);
    if (exp_l + exp_r > 0) chk({tag, "/motor_start"}, m_idx, SETTLE + 2 + d);
    acc = (d >= 1 && d <= TIMEOUT);
    b = model_bin(code);
    if (acc) begin
      m_disp = code;
      m_dvalid = 1;
      if (b == 1)      m_left++;
      else if (b == 2) m_right++;
      else             m_rej++;
    end else begin
      m_rej++;
      m_terr = 1;
    end
    check_state(tag);
  endtask

  initial begin
    vec_t vecs[$];
    rst = 1'b1; p = 1'b0; cls_valid = 1'b0; cls_code = 3'd0;
    model_clear();

    //          code d  jit L  R  busy
    vecs.push_back('{1, 1, 0, 4, 0, 10});  // red
    vecs.push_back('{3, 1, 0, 0, 4, 10});  // blue
    vecs.push_back('{5, 1, 0, 0, 4, 10});  // yellow, back-to-back
    vecs.push_back('{6, 1, 0, 0, 0, 10});  // white reject
    vecs.push_back('{0, 1, 0, 0, 0, 10});  // black reject
    vecs.push_back('{1, 0, 0, 0, 0, 13});  // classifier timeout
    vecs.push_back('{7, 1, 0, 4, 0, 10});  // orange after timeout
    vecs.push_back('{4, 8, 0, 4, 0, 17});  // valid on final timeout cycle
    vecs.push_back('{2, 3, 0, 0, 4, 12});  // green, late result
    vecs.push_back('{1, 2, 1, 4, 0, 11});  // extra P pulses while busy

    do_reset();

    foreach (vecs[i])
      apply_sort($sformatf("vec%0d", i), vecs[i].code, vecs[i].d, 1'b0,
                 vecs[i].jitter, vecs[i].exp_l, vecs[i].exp_r, vecs[i].exp_busy);

    // spurious classifier results while idle
    cls_valid = 1'b1; cls_code = 3'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("idle_valid%0d/busy", i), int'(bus.busy), 0);
    end
    cls_valid = 1'b0;
    @(negedge clk);
    check_state("idle_valid");

    for (int i = 0; i < 20; i++) begin
      int code, d, b, el, er, eb;
      bit acc;
      code = $urandom_range(0, 7);
      d    = $urandom_range(0, 10);
      acc  = (d >= 1 && d <= TIMEOUT);
      b    = model_bin(code);
      el   = (acc && b == 1) ? MOTOR : 0;
      er   = (acc && b == 2) ? MOTOR : 0;
      eb   = SETTLE + 1 + (acc ? d + MOTOR : TIMEOUT) + COOL;
      apply_sort($sformatf("rnd%0d", i), code, d, 1'($urandom_range(0, 1)),
                 2, el, er, eb);
    end

    // reset during the second DRIVE cycle
    begin
      int idx, nl;
      idx = 0; nl = 0;
      p = 1'b1;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (bus.busy) idx++;
        if (bus.motorL) nl++;
        if (nl == 2) begin
          rst = 1'b1;
          break;
        end
        p = (idx == 0);
        cls_valid = (idx == SETTLE + 2);
        cls_code  = 3'd1;
      end
      p = 1'b0; cls_valid = 1'b0;
      chk("rst_drive/reached", nl, 2);
      @(negedge clk);
      model_clear();
      chk("rst_drive/motorL", int'(bus.motorL), 0);
      chk("rst_drive/motorR", int'(bus.motorR), 0);
      chk("rst_drive/busy",   int'(bus.busy),   0);
      check_state("rst_drive");
      rst = 1'b0;
    end

    // saturation of the 2-bit instance: five red sorts
    do_reset();
    for (int i = 0; i < 5; i++)
      apply_sort($sformatf("sat%0d", i), 1, 1, 1'b0, 0, MOTOR, 0, 10);
    chk("sat/final_narrow", int'(bus2.cnt_left), 3);
    chk("sat/final_wide",   int'(bus.cnt_left),  5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
